// File: rtl/repne_writeback_ctrl_wb_pkg.sv
// Purpose: shared definitions for the REPNE writeback controller.
//   - REPNE iteration state encodings (2-bit, 11 is illegal)
//   - default datapath width and ZF bit position
//   - helper computing the loop termination condition
package repne_writeback_ctrl_wb_pkg;

    localparam int REPNE_DATA_W_DEF = 32;
    localparam int REPNE_ZF_BIT_DEF = 6;

    typedef enum logic [1:0] {
        REPNE_IDLE    = 2'b00,
        REPNE_ITER    = 2'b01,
        REPNE_TERM    = 2'b10,
        REPNE_ILLEGAL = 2'b11
    } repne_state_e;

    // The loop ends when the compare set ZF, or the decremented count
    // (already count-1 in result C) reached zero.
    function automatic logic repne_term_cond(input logic zf, input logic count_is_zero);
        return zf | count_is_zero;
    endfunction

endpackage

// File: rtl/repne_writeback_ctrl_wb_fsm.sv
// Purpose: REPNE CMPS iteration state machine and saved count register.
// Ports:
//   clk_i          clock, all state on rising edge
//   clr_i          synchronous active-high reset
//   retire_i       a REPNE CMPS compare uop retires this cycle
//   term_cond_i    the retiring compare ends the loop
//   ld_latches_i   WB latch load this cycle (releases TERM)
//   result_c_i     latched result C (count for the next iteration)
//   saved_count_o  count fed back to EX operand select
//   steady_o       high while iterating
//   terminate_o    high while terminating (kills the loop in EX)
module repne_fsm_wb
    import repne_writeback_ctrl_wb_pkg::*;
#(
    parameter int DATA_W = REPNE_DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic              retire_i,
    input  logic              term_cond_i,
    input  logic              ld_latches_i,
    input  logic [DATA_W-1:0] result_c_i,
    output logic [DATA_W-1:0] saved_count_o,
    output logic              steady_o,
    output logic              terminate_o
);

    repne_state_e      state_q, state_d;
    logic [DATA_W-1:0] count_q, count_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            REPNE_IDLE, REPNE_ITER: begin
                if (retire_i) begin
                    if (term_cond_i) begin
                        state_d = REPNE_TERM;
                    end else begin
                        state_d = REPNE_ITER;
                        count_d = result_c_i;
                    end
                end
            end
            REPNE_TERM: begin
                // Leave only on a latch load so the squash lines up with the
                // bubble entering WB; terminate stays up across stalls.
                if (ld_latches_i) begin
                    state_d = REPNE_IDLE;
                    count_d = '0;
                end
            end
            default: begin
                state_d = REPNE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q <= REPNE_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign saved_count_o = count_q;
    assign steady_o      = (state_q == REPNE_ITER);
    assign terminate_o   = (state_q == REPNE_TERM);

endmodule

// File: rtl/repne_writeback_ctrl_wb.sv
// Purpose: EX->WB pipeline latch bank plus REPNE CMPS iteration control.
// Ports:
//   CLK, CLR                       clock, synchronous active-high reset
//   WB_ld_latches                  load enable for the WB latches
//   WB_Stall                       WB cannot retire this cycle
//   WB_V_next, WB_RESULT_*_next,
//   WB_FLAGS_next, v_ex_ld_gpr1,
//   v_ex_dcache_write,
//   WB_de_repne_all_next,
//   CS_IS_CMPS_SECOND_UOP_next     values from EX captured on a latch load
//   WB_V, WB_RESULT_A/B/C,
//   WB_FLAGS, WB_ld_gpr1,
//   WB_dcache_write                latched WB stage values
//   saved_count                    count for the next REPNE iteration
//   CS_REPNE_STEADY_STATE_EX       loop is iterating
//   wb_repne_terminate_all         loop is being terminated
module repne_writeback_ctrl_wb
    import repne_writeback_ctrl_wb_pkg::*;
#(
    parameter int DATA_W = REPNE_DATA_W_DEF,
    parameter int ZF_BIT = REPNE_ZF_BIT_DEF
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              WB_ld_latches,
    input  logic              WB_Stall,
    input  logic              WB_V_next,
    input  logic [DATA_W-1:0] WB_RESULT_A_next,
    input  logic [DATA_W-1:0] WB_RESULT_B_next,
    input  logic [DATA_W-1:0] WB_RESULT_C_next,
    input  logic [DATA_W-1:0] WB_FLAGS_next,
    input  logic              v_ex_ld_gpr1,
    input  logic              v_ex_dcache_write,
    input  logic              WB_de_repne_all_next,
    input  logic              CS_IS_CMPS_SECOND_UOP_next,
    output logic              WB_V,
    output logic [DATA_W-1:0] WB_RESULT_A,
    output logic [DATA_W-1:0] WB_RESULT_B,
    output logic [DATA_W-1:0] WB_RESULT_C,
    output logic [DATA_W-1:0] WB_FLAGS,
    output logic              WB_ld_gpr1,
    output logic              WB_dcache_write,
    output logic [DATA_W-1:0] saved_count,
    output logic              CS_REPNE_STEADY_STATE_EX,
    output logic              wb_repne_terminate_all
);

    logic              v_q;
    logic [DATA_W-1:0] res_a_q, res_b_q, res_c_q, flags_q;
    logic              ld_gpr1_q, dcache_write_q;
    logic              repne_q, cmps_second_q;

    logic retire;
    logic term_cond;

    // WB latch bank: enabled registers, cleared by CLR (which wins over a load).
    always_ff @(posedge CLK) begin
        if (CLR) begin
            v_q            <= 1'b0;
            res_a_q        <= '0;
            res_b_q        <= '0;
            res_c_q        <= '0;
            flags_q        <= '0;
            ld_gpr1_q      <= 1'b0;
            dcache_write_q <= 1'b0;
            repne_q        <= 1'b0;
            cmps_second_q  <= 1'b0;
        end else if (WB_ld_latches) begin
            v_q            <= WB_V_next;
            res_a_q        <= WB_RESULT_A_next;
            res_b_q        <= WB_RESULT_B_next;
            res_c_q        <= WB_RESULT_C_next;
            flags_q        <= WB_FLAGS_next;
            ld_gpr1_q      <= v_ex_ld_gpr1;
            dcache_write_q <= v_ex_dcache_write;
            repne_q        <= WB_de_repne_all_next;
            cmps_second_q  <= CS_IS_CMPS_SECOND_UOP_next;
        end
    end

    assign retire    = v_q & ~WB_Stall & repne_q & cmps_second_q;
    assign term_cond = repne_term_cond(flags_q[ZF_BIT], (res_c_q == '0));

    repne_fsm_wb #(
        .DATA_W(DATA_W)
    ) u_fsm (
        .clk_i        (CLK),
        .clr_i        (CLR),
        .retire_i     (retire),
        .term_cond_i  (term_cond),
        .ld_latches_i (WB_ld_latches),
        .result_c_i   (res_c_q),
        .saved_count_o(saved_count),
        .steady_o     (CS_REPNE_STEADY_STATE_EX),
        .terminate_o  (wb_repne_terminate_all)
    );

    assign WB_V            = v_q;
    assign WB_RESULT_A     = res_a_q;
    assign WB_RESULT_B     = res_b_q;
    assign WB_RESULT_C     = res_c_q;
    assign WB_FLAGS        = flags_q;
    assign WB_ld_gpr1      = ld_gpr1_q;
    assign WB_dcache_write = dcache_write_q;

endmodule
